// File: rtl/ct_rtu_pst_vreg_pkg.sv
// Shared encodings and default sizing for the RTU vector preg state table.
// Optional feature macro used by the top: CT_RTU_PST_VREG_FREE_CNT_EN.
`default_nettype none

package ct_rtu_pst_vreg_pkg;

  typedef enum logic [1:0] {
    ST_FREE  = 2'b00,
    ST_RSVD  = 2'b01,
    ST_ALLOC = 2'b10,
    ST_WB    = 2'b11
  } vreg_state_e;

  localparam int PST_PREG_NUM  = 64;
  localparam int PST_PREG_W    = 6;
  localparam int PST_ALLOC_NUM = 4;
  localparam int PST_WB_NUM    = 3;
  localparam int PST_ARCH_NUM  = 32;

endpackage

`default_nettype wire

// File: rtl/ct_rtu_pst_vreg_ffn.sv
// Find-first-N: returns the ALLOC_NUM lowest set bits of the FREE vector
// as one-hot / index pairs, lowest index in pick 0.
`default_nettype none

module ct_rtu_pst_vreg_ffn
  import ct_rtu_pst_vreg_pkg::*;
#(
  parameter int PREG_NUM  = PST_PREG_NUM,
  parameter int PREG_W    = PST_PREG_W,
  parameter int ALLOC_NUM = PST_ALLOC_NUM
) (
  input  logic [PREG_NUM-1:0]                 free_vec_i,
  output logic [ALLOC_NUM-1:0][PREG_NUM-1:0]  pick_oh_o,
  output logic [ALLOC_NUM-1:0][PREG_W-1:0]    pick_idx_o,
  output logic [ALLOC_NUM-1:0]                pick_vld_o
);

  always_comb begin
    logic [PREG_NUM-1:0] remain;
    logic                found;
    remain     = free_vec_i;
    found      = 1'b0;
    pick_oh_o  = '0;
    pick_idx_o = '0;
    pick_vld_o = '0;
    for (int n = 0; n < ALLOC_NUM; n++) begin
      found = 1'b0;
      for (int i = 0; i < PREG_NUM; i++) begin
        if (!found && remain[i]) begin
          pick_oh_o[n][i] = 1'b1;
          pick_idx_o[n]   = PREG_W'(i);
          pick_vld_o[n]   = 1'b1;
          found           = 1'b1;
        end
      end
      // Strip the bit just taken so the next pick finds the next-lowest.
      remain = remain & ~pick_oh_o[n];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ct_rtu_pst_vreg_alloc.sv
// Vector physical-register state table: FREE/RSVD/ALLOC/WB tracking with IDU pre-allocation.
// Define CT_RTU_PST_VREG_FREE_CNT_EN to add the free-count and alloc-stall outputs.
`default_nettype none

module ct_rtu_pst_vreg_alloc
  import ct_rtu_pst_vreg_pkg::*;
#(
  parameter int PREG_NUM  = PST_PREG_NUM,
  parameter int PREG_W    = PST_PREG_W,
  parameter int ALLOC_NUM = PST_ALLOC_NUM,
  parameter int WB_NUM    = PST_WB_NUM,
  parameter int ARCH_NUM  = PST_ARCH_NUM
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst_b,
  input  logic [ALLOC_NUM-1:0]          idu_rtu_ir_xreg_alloc_vld,
  input  logic                          idu_rtu_ir_xreg_alloc_gateclk_vld,
  output logic [ALLOC_NUM*PREG_W-1:0]   rtu_idu_alloc_xreg,
  output logic [ALLOC_NUM-1:0]          rtu_idu_alloc_xreg_vld,
  input  logic [WB_NUM-1:0]             wb_vreg_vld,
  input  logic [WB_NUM*PREG_NUM-1:0]    wb_vreg_expand,
  input  logic [PREG_NUM-1:0]           idu_rtu_pst_xreg_dealloc_mask,
  input  logic                          rtu_yy_xx_flush,
  input  logic [PREG_NUM-1:0]           rt_retired_vreg_mask,
  output logic                          pst_retired_xreg_wb
`ifdef CT_RTU_PST_VREG_FREE_CNT_EN
  ,
  output logic [PREG_W:0]               pst_vreg_free_cnt,
  output logic                          pst_vreg_alloc_stall
`endif
);

  vreg_state_e                          state_q [PREG_NUM];
  vreg_state_e                          state_d [PREG_NUM];
  logic [ALLOC_NUM-1:0][PREG_W-1:0]     slot_idx_q, slot_idx_d;
  logic [ALLOC_NUM-1:0]                 slot_vld_q, slot_vld_d;
  logic                                 retired_wb_q;

  logic [PREG_NUM-1:0]                  free_vec;
  logic [PREG_NUM-1:0]                  alloc_vec;
  logic [PREG_NUM-1:0]                  wb_hit;
  logic [PREG_NUM-1:0]                  consume_mask;
  logic [PREG_NUM-1:0]                  refill_mask;
  logic [ALLOC_NUM-1:0]                 consume;
  logic [ALLOC_NUM-1:0]                 need;
  logic [ALLOC_NUM-1:0][PREG_NUM-1:0]   ffn_oh;
  logic [ALLOC_NUM-1:0][PREG_W-1:0]     ffn_idx;
  logic [ALLOC_NUM-1:0]                 ffn_vld;

  // The gate-clock hint carries no function in this table.
  logic unused_gateclk;
  assign unused_gateclk = idu_rtu_ir_xreg_alloc_gateclk_vld;

  always_comb begin
    free_vec  = '0;
    alloc_vec = '0;
    for (int i = 0; i < PREG_NUM; i++) begin
      free_vec[i]  = (state_q[i] == ST_FREE);
      alloc_vec[i] = (state_q[i] == ST_ALLOC);
    end
  end

  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < WB_NUM; p++) begin
      if (wb_vreg_vld[p]) begin
        wb_hit = wb_hit | wb_vreg_expand[p*PREG_NUM +: PREG_NUM];
      end
    end
  end

  assign consume = idu_rtu_ir_xreg_alloc_vld & slot_vld_q;
  assign need    = ~slot_vld_q | consume;

  always_comb begin
    consume_mask = '0;
    for (int k = 0; k < ALLOC_NUM; k++) begin
      if (consume[k]) begin
        consume_mask[slot_idx_q[k]] = 1'b1;
      end
    end
  end

  ct_rtu_pst_vreg_ffn #(
    .PREG_NUM  (PREG_NUM),
    .PREG_W    (PREG_W),
    .ALLOC_NUM (ALLOC_NUM)
  ) u_ffn (
    .free_vec_i (free_vec),
    .pick_oh_o  (ffn_oh),
    .pick_idx_o (ffn_idx),
    .pick_vld_o (ffn_vld)
  );

  // Hand the found entries to the slots needing refill in ascending slot order.
  always_comb begin
    int   pick;
    logic done;
    pick        = 0;
    done        = 1'b0;
    slot_idx_d  = slot_idx_q;
    slot_vld_d  = slot_vld_q & ~consume;
    refill_mask = '0;
    for (int k = 0; k < ALLOC_NUM; k++) begin
      done = 1'b0;
      if (need[k]) begin
        for (int j = 0; j < ALLOC_NUM; j++) begin
          if (!done && (pick == j) && ffn_vld[j]) begin
            slot_idx_d[k] = ffn_idx[j];
            slot_vld_d[k] = 1'b1;
            refill_mask   = refill_mask | ffn_oh[j];
            pick          = pick + 1;
            done          = 1'b1;
          end
        end
      end
    end
    if (rtu_yy_xx_flush) begin
      slot_vld_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < PREG_NUM; i++) begin
      if (rtu_yy_xx_flush) begin
        state_d[i] = rt_retired_vreg_mask[i] ? ST_WB : ST_FREE;
      end else if (idu_rtu_pst_xreg_dealloc_mask[i] &&
                   ((state_q[i] == ST_ALLOC) || (state_q[i] == ST_WB))) begin
        state_d[i] = ST_FREE;
      end else if (wb_hit[i] && (state_q[i] == ST_ALLOC)) begin
        state_d[i] = ST_WB;
      end else if (consume_mask[i] && (state_q[i] == ST_RSVD)) begin
        state_d[i] = ST_ALLOC;
      end else if (refill_mask[i]) begin
        state_d[i] = ST_RSVD;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < PREG_NUM; i++) begin
        state_q[i] <= (i < ARCH_NUM) ? ST_WB : ST_FREE;
      end
      slot_idx_q   <= '0;
      slot_vld_q   <= '0;
      retired_wb_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      slot_idx_q   <= slot_idx_d;
      slot_vld_q   <= slot_vld_d;
      retired_wb_q <= ~|alloc_vec;
    end
  end

  assign rtu_idu_alloc_xreg     = slot_idx_q;
  assign rtu_idu_alloc_xreg_vld = slot_vld_q;
  assign pst_retired_xreg_wb    = retired_wb_q;

`ifdef CT_RTU_PST_VREG_FREE_CNT_EN
  logic [PREG_W:0] free_cnt_q, free_cnt_d;
  logic            stall_q, stall_d;

  always_comb begin
    free_cnt_d = '0;
    for (int i = 0; i < PREG_NUM; i++) begin
      if (state_d[i] == ST_FREE) begin
        free_cnt_d = free_cnt_d + (PREG_W+1)'(1);
      end
    end
  end

  // A slot that needed an entry yet stays empty was starved; flush-cleared slots are not.
  assign stall_d = ~rtu_yy_xx_flush & (|(need & ~slot_vld_d));

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      free_cnt_q <= (PREG_W+1)'(PREG_NUM - ARCH_NUM);
      stall_q    <= 1'b0;
    end else begin
      free_cnt_q <= free_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign pst_vreg_free_cnt    = free_cnt_q;
  assign pst_vreg_alloc_stall = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ct_rtu_pst_vreg_alloc.sv
// Scoreboard bench for ct_rtu_pst_vreg_alloc: directed stimulus pushes expected outputs, negedge monitor checks them.
`default_nettype none

module tb_ct_rtu_pst_vreg_alloc;

  localparam int SEL_IDX = 0;
  localparam int SEL_VLD = 1;
  localparam int SEL_RET = 2;
  localparam int SEL_CNT = 3;
  localparam int SEL_STL = 4;

  logic               clk;
  logic               rst_n;
  logic [3:0]         alloc_vld;
  logic               gateclk;
  logic [23:0]        alloc_xreg;
  logic [3:0]         alloc_xreg_vld;
  logic [2:0]         wb_vld;
  logic [191:0]       wb_expand;
  logic [63:0]        dealloc_mask;
  logic               flush;
  logic [63:0]        retired_mask;
  logic               retired_wb;
`ifdef CT_RTU_PST_VREG_FREE_CNT_EN
  logic [6:0]         free_cnt;
  logic               alloc_stall;
`endif

  ct_rtu_pst_vreg_alloc dut (
    .forever_cpuclk                    (clk),
    .cpurst_b                          (rst_n),
    .idu_rtu_ir_xreg_alloc_vld         (alloc_vld),
    .idu_rtu_ir_xreg_alloc_gateclk_vld (gateclk),
    .rtu_idu_alloc_xreg                (alloc_xreg),
    .rtu_idu_alloc_xreg_vld            (alloc_xreg_vld),
    .wb_vreg_vld                       (wb_vld),
    .wb_vreg_expand                    (wb_expand),
    .idu_rtu_pst_xreg_dealloc_mask     (dealloc_mask),
    .rtu_yy_xx_flush                   (flush),
    .rt_retired_vreg_mask              (retired_mask),
    .pst_retired_xreg_wb               (retired_wb)
`ifdef CT_RTU_PST_VREG_FREE_CNT_EN
    ,
    .pst_vreg_free_cnt                 (free_cnt),
    .pst_vreg_alloc_stall              (alloc_stall)
`endif
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {8'h0, 6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SEL_IDX: return {8'h0, alloc_xreg};
      SEL_VLD: return {28'h0, alloc_xreg_vld};
      SEL_RET: return {31'h0, retired_wb};
`ifdef CT_RTU_PST_VREG_FREE_CNT_EN
      SEL_CNT: return {25'h0, free_cnt};
      SEL_STL: return {31'h0, alloc_stall};
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input int dly, input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic expect_cnt(input int dly, input int cnt, input int stl, input string name);
`ifdef CT_RTU_PST_VREG_FREE_CNT_EN
    expect_at(dly, SEL_CNT, 32'(cnt), {name, "_free_cnt"});
    expect_at(dly, SEL_STL, 32'(stl), {name, "_stall"});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        keep[$];
    logic [31:0] act;
    keep = {};
    foreach (sbq[i]) begin
      if (sbq[i].cyc == cyc) begin
        checks++;
        act = actual(sbq[i].sel);
        if (act !== sbq[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h expected=%0h", sbq[i].name, cyc, act, sbq[i].val);
        end
      end else begin
        keep.push_back(sbq[i]);
      end
    end
    sbq = keep;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    alloc_vld    = '0;
    gateclk      = 1'b0;
    wb_vld       = '0;
    wb_expand    = '0;
    dealloc_mask = '0;
    flush        = 1'b0;
    retired_mask = '0;

    tick(); tick();
    expect_at(0, SEL_IDX, 32'h0, "reset_idx");
    expect_at(0, SEL_VLD, 32'h0, "reset_vld");
    expect_at(0, SEL_RET, 32'h1, "reset_ret");
    expect_cnt(0, 32, 0, "reset");
    rst_n = 1'b1;
    expect_at(1, SEL_IDX, pk(32, 33, 34, 35), "init_idx");
    expect_at(1, SEL_VLD, 32'hF, "init_vld");
    expect_at(1, SEL_RET, 32'h1, "init_ret");
    expect_cnt(1, 28, 0, "init");

    tick();
    checks++;
    if (alloc_xreg !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
      failures++;
      $display("FAIL direct_init_idx actual=%0h", alloc_xreg);
    end
    checks++;
    if (alloc_xreg_vld !== 4'hF) begin
      failures++;
      $display("FAIL direct_init_vld actual=%0h", alloc_xreg_vld);
    end
    checks++;
    if (retired_wb !== 1'b1) begin
      failures++;
      $display("FAIL direct_init_ret actual=%0h", retired_wb);
    end
    alloc_vld = 4'b0101;
    expect_at(1, SEL_IDX, pk(36, 33, 37, 35), "consume02_idx");
    expect_at(1, SEL_VLD, 32'hF, "consume02_vld");
    expect_at(1, SEL_RET, 32'h1, "consume02_ret_lag");
    expect_at(2, SEL_RET, 32'h0, "consume02_ret");

    tick();
    alloc_vld = '0;
    wb_vld    = 3'b011;
    wb_expand = '0;
    wb_expand[1*64 + 32] = 1'b1;
    wb_expand[0*64 + 34] = 1'b1;
    expect_at(1, SEL_IDX, pk(36, 33, 37, 35), "wb_idx_hold");
    expect_at(1, SEL_RET, 32'h0, "wb_ret_lag");
    expect_at(2, SEL_RET, 32'h1, "wb_ret");

    tick();
    wb_vld    = 3'b100;
    wb_expand = '0;
    wb_expand[2*64 + 5] = 1'b1;
    dealloc_mask[5] = 1'b1;

    tick();
    wb_vld       = '0;
    wb_expand    = '0;
    dealloc_mask = '0;
    alloc_vld    = 4'b0010;
    expect_at(1, SEL_IDX, pk(36, 5, 37, 35), "dealloc5_refill_idx");
    expect_at(1, SEL_RET, 32'h1, "dealloc5_ret");
    expect_at(2, SEL_RET, 32'h0, "consume1_ret");

    tick();
    alloc_vld = 4'hF;
    expect_at(1, SEL_IDX, pk(38, 39, 40, 41), "drain_first_idx");
    expect_at(1, SEL_VLD, 32'hF, "drain_first_vld");
    expect_cnt(1, 22, 0, "drain_first");
    repeat (6) tick();
    tick();
    expect_at(0, SEL_IDX, pk(62, 63, 60, 61), "drain_partial_idx");
    expect_at(0, SEL_VLD, 32'h3, "drain_partial_vld");
    expect_cnt(0, 0, 1, "drain_partial");
    expect_at(1, SEL_VLD, 32'h0, "drain_empty_vld");
    expect_at(1, SEL_IDX, pk(62, 63, 60, 61), "drain_empty_idx");
    expect_at(1, SEL_RET, 32'h0, "drain_ret");
    expect_cnt(1, 0, 1, "drain_empty");

    tick();
    alloc_vld = '0;

    tick();
    flush        = 1'b1;
    retired_mask = 64'h0000_0000_FFFF_FFFF;
    alloc_vld    = 4'hF;
    expect_at(1, SEL_VLD, 32'h0, "flush_vld");
    expect_at(1, SEL_RET, 32'h0, "flush_ret_lag");
    expect_cnt(1, 32, 0, "flush");
    expect_at(2, SEL_IDX, pk(32, 33, 34, 35), "post_flush_idx");
    expect_at(2, SEL_VLD, 32'hF, "post_flush_vld");
    expect_at(2, SEL_RET, 32'h1, "post_flush_ret");
    expect_cnt(2, 28, 0, "post_flush");

    tick();
    flush        = 1'b0;
    retired_mask = '0;
    alloc_vld    = '0;

    tick(); tick();
    rst_n = 1'b0;
    expect_at(0, SEL_IDX, 32'h0, "async_reset_idx");
    expect_at(0, SEL_VLD, 32'h0, "async_reset_vld");
    expect_at(0, SEL_RET, 32'h1, "async_reset_ret");
    expect_cnt(0, 32, 0, "async_reset");
    #1;
    checks++;
    if (alloc_xreg_vld !== 4'h0) begin
      failures++;
      $display("FAIL direct_async_reset_vld actual=%0h", alloc_xreg_vld);
    end

    @(negedge clk);
    @(negedge clk);
    foreach (sbq[i]) begin
      failures++;
      $display("FAIL unchecked_%s due_cyc=%0d now=%0d", sbq[i].name, sbq[i].cyc, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
